bandgap_seq_ctrl: RTL
=====================

Name: bandgap_seq_ctrl

Overview:
Digital startup sequencer and health monitor for the on-chip bandgap reference. It drives the bandgap enable, waits for a settle time, and qualifies the analog "VBGP in range" comparator output. It asserts a ready flag only after the reference is stable, and retries or latches a fault when the reference fails to come up or drops out. It sits in the user project between logic-analyzer/management control bits and the bandgap macro's EN input and comparator output.

Parameters:
CNT_W, 16, width of the settle/timeout/cooldown counter; every cycle-count parameter must be in the range 1..2^CNT_W-1
SETTLE_CYCLES, 16, cycles EN is held high before comparator checking starts
OK_FILTER, 4, consecutive synced comparator cycles needed to declare good (in CHECK) or lost (in ON)
TIMEOUT_CYCLES, 64, maximum cycles spent in CHECK before a retry is triggered
COOLDOWN_CYCLES, 8, cycles EN is held low between retries
MAX_RETRIES, 2, retries allowed before FAULT; retry counter width is 4 bits

Ports:
wb_clk_i  input  1  single clock; all state changes on the rising edge
wb_rst_i  input  1  reset, synchronous and active-high
req_i  input  1  enable request from management/LA; level-sensitive
vbg_ok_i  input  1  asynchronous comparator output from the analog domain, high when VBGP is in range
clr_fault_i  input  1  clears FAULT; level-sensitive
en_o  output  1  bandgap enable (drives the macro's EN)
ready_o  output  1  reference qualified and stable
fault_o  output  1  sequencer has given up
state_o  output  3  current state encoding
retry_o  output  4  retries consumed since the last OFF

Behaviour:
- Reset, sampled at the clock edge while wb_rst_i=1:
  - state goes to OFF; en_o, ready_o and fault_o go to 0; retry_o goes to 0.
  - All counters and both synchroniser flops go to 0.
  - Reset has priority over every other event, including mid-sequence and in FAULT.
- vbg_ok_i passes through a 2-flop synchroniser giving ok_s, 2 cycles of latency. Only ok_s is used internally.
- All outputs are Moore outputs decoded from the registered state.
- State encodings: OFF=0, STARTUP=1, CHECK=2, ON=3, COOLDOWN=4, FAULT=5. Codes 6 and 7 are illegal and return to OFF on the next edge.
- OFF:
  - en_o=0.
  - req_i=1 moves to STARTUP with cnt=0.
  - retry_o is cleared on entry to OFF.
- STARTUP:
  - en_o=1; cnt increments every cycle.
  - When cnt==SETTLE_CYCLES-1, move to CHECK with cnt=0 and run=0.
- CHECK:
  - en_o=1.
  - run increments while ok_s=1 and clears to 0 when ok_s=0.
  - When run reaches OK_FILTER, move to ON.
  - Otherwise, when cnt==TIMEOUT_CYCLES-1, take the retry path.
  - If run reaches OK_FILTER on the same cycle as the timeout, ON wins.
- ON:
  - en_o=1, ready_o=1.
  - run counts consecutive ok_s=0 cycles.
  - When run reaches OK_FILTER, take the retry path.
- Retry path:
  - If retry_o < MAX_RETRIES: increment retry_o and move to COOLDOWN with cnt=0.
  - Otherwise move to FAULT.
- COOLDOWN:
  - en_o=0.
  - When cnt==COOLDOWN_CYCLES-1, move to STARTUP with cnt=0.
- FAULT:
  - en_o=0, fault_o=1.
  - Stays in FAULT until clr_fault_i=1 and req_i=0 on the same edge, then moves to OFF.
  - req_i alone never exits FAULT.
- req_i=0 in STARTUP, CHECK, ON or COOLDOWN moves to OFF on the next edge.
  - This takes priority over settle, filter, timeout and cooldown transitions.
  - It sets en_o=0 and ready_o=0 one cycle later.
- Counters saturate and never wrap. They are cleared on every state entry.

Test Plan:
- Clean start (defaults, vbg_ok_i=1 throughout):
  - req_i rises at edge 0 -> en_o=1 from edge 1.
  - CHECK from edge 17; ready_o=1 from edge 21; retry_o=0.
- Timeout with retries (vbg_ok_i=0 forever, req_i=1):
  - 3 CHECK timeouts of 64 cycles each, separated by 8-cycle COOLDOWNs with en_o=0.
  - After the third timeout -> FAULT, fault_o=1, en_o=0, retry_o=2.
- Dropout in ON:
  - Reach ON, then hold vbg_ok_i low for 3 cycles -> still ON, ready_o=1.
  - Hold it low for 6 cycles -> COOLDOWN, ready_o=0, retry_o=1, then re-enters STARTUP.
- Glitch filtering in CHECK:
  - Toggle vbg_ok_i 1,1,1,0 repeatedly -> never reaches ON; times out at 64 cycles.
- Request drop / fault clear:
  - Deassert req_i mid-STARTUP at cnt=5 -> OFF next edge, en_o=0.
  - In FAULT, clr_fault_i=1 with req_i=1 -> stays FAULT.
  - With req_i=0 -> OFF and retry_o=0.
- Synchronous reset:
  - Assert wb_rst_i for 1 cycle while in ON -> next edge state_o=0 and en_o, ready_o, fault_o = 0.
  - Asserting wb_rst_i between edges without a clock edge changes nothing.

Source files
------------

// File: rtl/bandgap_seq_ctrl.sv
// rtl/bandgap_seq_ctrl.sv - bandgap reference startup sequencer and health monitor
module bandgap_seq_ctrl #(
    parameter int CNT_W           = 16,
    parameter int SETTLE_CYCLES   = 16,
    parameter int OK_FILTER       = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int MAX_RETRIES     = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_i,
    input  logic       vbg_ok_i,
    input  logic       clr_fault_i,
    output logic       en_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_o
);
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_STARTUP  = 3'd1,
        ST_CHECK    = 3'd2,
        ST_ON       = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_N      = CNT_W'(OK_FILTER);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [3:0]       RETRY_MAX     = 4'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] run_q, run_d, run_inc;
    logic [3:0]       retry_q, retry_d;
    logic [1:0]       sync_q;
    logic             ok_s;
    logic             retry_path;

    assign ok_s    = sync_q[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign run_inc = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        run_d      = run_q;
        retry_d    = retry_q;
        retry_path = 1'b0;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (req_i) state_d = ST_STARTUP;
            end
            ST_STARTUP: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // a good filter result beats a timeout landing on the same edge
                run_d = ok_s ? run_inc : '0;
                if (ok_s && run_inc >= FILTER_N) state_d = ST_ON;
                else if (cnt_q == TIMEOUT_LAST) retry_path = 1'b1;
            end
            ST_ON: begin
                cnt_d = '0;
                run_d = ok_s ? '0 : run_inc;
                if (!ok_s && run_inc >= FILTER_N) retry_path = 1'b1;
            end
            ST_COOLDOWN: begin
                if (cnt_q == COOLDOWN_LAST) state_d = ST_STARTUP;
            end
            ST_FAULT: begin
                cnt_d = '0;
                if (clr_fault_i && !req_i) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        if (retry_path) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_COOLDOWN;
            end else begin
                state_d = ST_FAULT;
            end
        end

        // dropping the request overrides any sequencing decision
        if (!req_i && (state_q inside {ST_STARTUP, ST_CHECK, ST_ON, ST_COOLDOWN}))
            state_d = ST_OFF;

        if (state_d != state_q) begin
            cnt_d = '0;
            run_d = '0;
        end
        if (state_d == ST_OFF) retry_d = '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            run_q   <= '0;
            retry_q <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            retry_q <= retry_d;
            sync_q  <= {sync_q[0], vbg_ok_i};
        end
    end

    assign en_o    = state_q inside {ST_STARTUP, ST_CHECK, ST_ON};
    assign ready_o = (state_q == ST_ON);
    assign fault_o = (state_q == ST_FAULT);
    assign state_o = state_q;
    assign retry_o = retry_q;
endmodule
